// File: rtl/gray_pkg.sv
// Shared constants and helpers for the pipelined Gray/binary converter.
package gray_pkg;

  // Widest word the helper functions handle; WIDTH must stay below this.
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } mode_e;

  // Binary to Gray on a zero-extended word; callers keep their low WIDTH bits.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int chunk_sz(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Highest bit resolved by stage k; negative when the stage has no bits.
  function automatic int chunk_hi(input int k, input int width, input int stages);
    return width - 1 - k * chunk_sz(width, stages);
  endfunction

  // Lowest bit resolved by stage k, clamped at bit 0.
  function automatic int chunk_lo(input int k, input int width, input int stages);
    int lo;
    lo = width - (k + 1) * chunk_sz(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One pipeline stage: valid/mode/data register plus the slice of the
// Gray->binary prefix-XOR chain owned by this stage. Stage 0 also performs
// the whole binary->Gray conversion; later stages pass such words through.
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid_i,
  input  logic             up_mode_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic             dn_mode_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i
);

  localparam int  HI        = chunk_hi(int'(IDX), int'(WIDTH), int'(STAGES));
  localparam int  LO        = chunk_lo(int'(IDX), int'(WIDTH), int'(STAGES));
  // The chain enters from the lowest bit already resolved upstream.
  localparam bit  HAS_CARRY = (HI >= 0) && (HI < int'(WIDTH) - 1);
  localparam int  CARRY_IDX = HAS_CARRY ? HI + 1 : 0;

  logic             valid_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [MAX_W-1:0] gray_full;
  logic             gray_unused;
  logic             acc;

  assign up_ready_o  = ~valid_q | dn_ready_i;
  assign dn_valid_o  = valid_q;
  assign dn_mode_o   = mode_q;
  assign dn_data_o   = data_q;
  assign gray_unused = |gray_full[MAX_W-1:WIDTH];

  // Convert the incoming word for this stage's share of the work.
  always_comb begin
    data_d    = up_data_i;
    gray_full = bin2gray(MAX_W'(up_data_i));
    acc       = HAS_CARRY ? up_data_i[CARRY_IDX] : 1'b0;
    if (up_mode_i == MODE_B2G) begin
      if (IDX == 0) data_d = gray_full[WIDTH-1:0];
    end else begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if ((int'(WIDTH - 1 - j) <= HI) && (int'(WIDTH - 1 - j) >= LO)) begin
          acc                   = acc ^ up_data_i[WIDTH-1-j];
          data_d[WIDTH - 1 - j] = acc;
        end
      end
    end
  end

  // Stage register: loads whenever empty or its content moves downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_G2B;
      data_q  <= '0;
    end else if (up_ready_o) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        mode_q <= up_mode_i;
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined Gray<->binary converter with valid/ready on both sides.
// Fixed latency of STAGES cycles; ready ripples back through the stage
// valids so in_ready never depends on in_valid.
module gray_bin_conv_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);

  // Index 0 is the input port; index k+1 is the output of stage k.
  logic             valid_s [STAGES+1];
  logic             mode_s  [STAGES+1];
  logic             ready_s [STAGES+1];
  logic [WIDTH-1:0] data_s  [STAGES+1];

  assign valid_s[0]      = in_valid;
  assign mode_s[0]       = in_mode;
  assign data_s[0]       = in_data;
  assign ready_s[STAGES] = out_ready;

  assign in_ready  = ready_s[0];
  assign out_valid = valid_s[STAGES];
  assign out_mode  = mode_s[STAGES];
  assign out_data  = data_s[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gray_conv_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid_i(valid_s[k]),
      .up_mode_i (mode_s[k]),
      .up_data_i (data_s[k]),
      .up_ready_o(ready_s[k]),
      .dn_valid_o(valid_s[k+1]),
      .dn_mode_o (mode_s[k+1]),
      .dn_data_o (data_s[k+1]),
      .dn_ready_i(ready_s[k+1])
    );
  end

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for gray_bin_conv_pipe at three parameter points.
module tb_gray_bin_conv_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // A: WIDTH=8 STAGES=2
  logic a_iv, a_ir, a_im, a_ov, a_or, a_om;
  logic [7:0] a_id, a_od;
  // B: WIDTH=3 STAGES=3
  logic b_iv, b_ir, b_im, b_ov, b_or, b_om;
  logic [2:0] b_id, b_od;
  // C: WIDTH=13 STAGES=4
  logic c_iv, c_ir, c_im, c_ov, c_or, c_om;
  logic [12:0] c_id, c_od;

  gray_bin_conv_pipe #(.WIDTH(8), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_im),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_mode(a_om), .out_data(a_od));

  gray_bin_conv_pipe #(.WIDTH(3), .STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_im),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_mode(b_om), .out_data(b_od));

  gray_bin_conv_pipe #(.WIDTH(13), .STAGES(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_mode(c_im),
    .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_mode(c_om), .out_data(c_od));

  // Reference Gray->binary, bit-serial from the MSB.
  function automatic logic [15:0] ref_g2b(input logic [15:0] g, input int w);
    logic [15:0] b;
    b = '0;
    for (int i = w - 1; i >= 0; i--) begin
      if (i == w - 1) b[i] = g[i];
      else            b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [7:0] model8(input logic m, input logic [7:0] d);
    logic [15:0] t;
    if (m) t = {8'h00, d} ^ ({8'h00, d} >> 1);
    else   t = ref_g2b({8'h00, d}, 8);
    return t[7:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_iv = 0; a_im = 0; a_id = '0; a_or = 1;
    b_iv = 0; b_im = 0; b_id = '0; b_or = 1;
    c_iv = 0; c_im = 0; c_id = '0; c_or = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({a_ov, a_om, a_od} !== 10'b0) begin
      n_fail++; $display("FAIL reset_out: got %b want 0", {a_ov, a_om, a_od});
    end
    n_tests++;
    if ({a_ir, b_ir, c_ir} !== 3'b111) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 111", {a_ir, b_ir, c_ir});
    end
    n_tests++;
    if ({b_ov, c_ov} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid_bc: got %b want 00", {b_ov, c_ov});
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    a_or = 1; a_iv = 1; a_im = 0; a_id = 8'hC0;
    #1;
    n_tests++;
    if (a_ir !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", a_ir); end
    @(negedge clk);
    a_iv = 0;
    #1;
    n_tests++;
    if (a_ov !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", a_ov); end
    @(negedge clk);
    #1;
    n_tests++;
    if ({a_ov, a_om, a_od} !== {1'b1, 1'b0, 8'h80}) begin
      n_fail++; $display("FAIL single_out: got %b/%b/%h want 1/0/80", a_ov, a_om, a_od);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (a_ov !== 1'b0) begin n_fail++; $display("FAIL single_after: got %b want 0", a_ov); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] din  [4] = '{8'hFF, 8'h0F, 8'h00, 8'hAA};
    logic       mdin [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] dexp [4] = '{8'hAA, 8'h08, 8'h00, 8'hFF};
    a_or = 1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin a_iv = 1; a_im = mdin[c]; a_id = din[c]; end
      else a_iv = 0;
      #1;
      if (c >= 2 && c < 6) begin
        n_tests++;
        if ({a_ov, a_om, a_od} !== {1'b1, mdin[c-2], dexp[c-2]}) begin
          n_fail++;
          $display("FAIL b2b_word%0d: got %b/%b/%h want 1/%b/%h", c - 2, a_ov, a_om, a_od,
                   mdin[c-2], dexp[c-2]);
        end
      end
      if (c == 6) begin
        n_tests++;
        if (a_ov !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", a_ov); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure_fill();
    a_or = 0; a_iv = 1; a_im = 0;
    a_id = 8'h11; #1;
    n_tests++;
    if (a_ir !== 1'b1) begin n_fail++; $display("FAIL fill_acc1: got %b want 1", a_ir); end
    @(negedge clk);
    a_id = 8'h22; #1;
    n_tests++;
    if (a_ir !== 1'b1) begin n_fail++; $display("FAIL fill_acc2: got %b want 1", a_ir); end
    @(negedge clk);
    a_id = 8'h33;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if ({a_ir, a_ov, a_od} !== {1'b0, 1'b1, 8'h1E}) begin
        n_fail++; $display("FAIL fill_full%0d: got %b/%b/%h want 0/1/1e", c, a_ir, a_ov, a_od);
      end
      @(negedge clk);
    end
    a_or = 1; #1;
    n_tests++;
    if ({a_ir, a_ov, a_od} !== {1'b1, 1'b1, 8'h1E}) begin
      n_fail++; $display("FAIL fill_swap: got %b/%b/%h want 1/1/1e", a_ir, a_ov, a_od);
    end
    @(negedge clk);
    a_iv = 0; #1;
    n_tests++;
    if ({a_ov, a_od} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL fill_out2: got %b/%h want 1/3c", a_ov, a_od);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({a_ov, a_od} !== {1'b1, 8'h22}) begin
      n_fail++; $display("FAIL fill_out3: got %b/%h want 1/22", a_ov, a_od);
    end
    @(negedge clk); #1;
    n_tests++;
    if (a_ov !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b want 0", a_ov); end
    @(negedge clk);
  endtask

  task automatic test_backpressure_random();
    logic [8:0] q[$];
    logic [8:0] e, pd;
    logic       pv, pr, acc;
    int         sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; pv = 0; pr = 0; pd = '0;
    a_iv = 0;
    while (rcvd < 200 && cyc < 4000) begin
      a_or = ($urandom_range(0, 2) != 0);
      if (sent < 200 && !a_iv) begin
        a_iv = 1; a_im = 1'($urandom_range(0, 1)); a_id = 8'($urandom);
      end
      #1;
      if (pv && !pr) begin
        n_tests++;
        if ({a_ov, a_om, a_od} !== {1'b1, pd}) begin
          n_fail++; $display("FAIL rand_hold: got %b/%b/%h want 1/%h", a_ov, a_om, a_od, pd);
        end
      end
      acc = a_iv && a_ir;
      if (acc) begin q.push_back({a_im, model8(a_im, a_id)}); sent++; end
      if (a_ov && a_or) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got %b/%h want none", a_om, a_od);
        end else begin
          e = q.pop_front();
          if ({a_om, a_od} !== e) begin
            n_fail++; $display("FAIL rand_word%0d: got %b/%h want %h", rcvd, a_om, a_od, e);
          end
        end
        rcvd++;
      end
      pv = a_ov; pr = a_or; pd = {a_om, a_od};
      cyc++;
      @(negedge clk);
      if (acc) a_iv = 0;
    end
    a_iv = 0; a_or = 1;
    n_tests++;
    if (rcvd != 200 || q.size() != 0) begin
      n_fail++; $display("FAIL rand_count: got %0d words (%0d pending) want 200", rcvd, q.size());
    end
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rand_tail: got %b want 0", a_ov); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    a_or = 1; a_iv = 1; a_im = 0; a_id = 8'h55;
    @(negedge clk);
    a_id = 8'h66;
    @(negedge clk);
    a_iv = 0; a_or = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1; a_or = 1;
    #1;
    n_tests++;
    if ({a_ov, a_ir} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_flush: got valid=%b ready=%b want 0/1", a_ov, a_ir);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_tests++;
      if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale%0d: got %b want 0", c, a_ov); end
    end
    @(negedge clk);
    a_iv = 1; a_im = 0; a_id = 8'h01;
    @(negedge clk);
    a_iv = 0;
    @(negedge clk); #1;
    n_tests++;
    if ({a_ov, a_om, a_od} !== {1'b1, 1'b0, 8'h01}) begin
      n_fail++; $display("FAIL rstmid_after: got %b/%b/%h want 1/0/01", a_ov, a_om, a_od);
    end
    @(negedge clk);
  endtask

  task automatic test_w3_exhaustive();
    logic [2:0] exp3 [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd7, 3'd6, 3'd4, 3'd5};
    b_or = 1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin b_iv = 1; b_im = 0; b_id = 3'(c); end
      else b_iv = 0;
      #1;
      if (c == 2) begin
        n_tests++;
        if (b_ov !== 1'b0) begin n_fail++; $display("FAIL w3_latency: got %b want 0", b_ov); end
      end
      if (c >= 3 && c < 11) begin
        n_tests++;
        if ({b_ov, b_om, b_od} !== {1'b1, 1'b0, exp3[c-3]}) begin
          n_fail++;
          $display("FAIL w3_g%0d: got %b/%b/%b want 1/0/%b", c - 3, b_ov, b_om, b_od, exp3[c-3]);
        end
      end
      if (c == 11) begin
        n_tests++;
        if (b_ov !== 1'b0) begin n_fail++; $display("FAIL w3_drain: got %b want 0", b_ov); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_w13_roundtrip();
    logic [12:0] res [8192];
    logic [15:0] r;
    c_or = 1;
    for (int c = 0; c < 8192 + 4; c++) begin
      if (c < 8192) begin c_iv = 1; c_im = 0; c_id = 13'(c); end
      else c_iv = 0;
      #1;
      if (c == 3) begin
        n_tests++;
        if (c_ov !== 1'b0) begin n_fail++; $display("FAIL w13_latency: got %b want 0", c_ov); end
      end
      if (c >= 4) begin
        r = ref_g2b(16'(c - 4), 13);
        n_tests++;
        if ({c_ov, c_om, c_od} !== {1'b1, 1'b0, r[12:0]}) begin
          n_fail++;
          $display("FAIL w13_g2b_%0d: got %b/%b/%h want 1/0/%h", c - 4, c_ov, c_om, c_od, r[12:0]);
        end
        res[c-4] = c_od;
      end
      @(negedge clk);
    end
    for (int c = 0; c < 8192 + 5; c++) begin
      if (c < 8192) begin c_iv = 1; c_im = 1; c_id = res[c]; end
      else c_iv = 0;
      #1;
      if (c >= 4 && c < 8192 + 4) begin
        n_tests++;
        if ({c_ov, c_om, c_od} !== {1'b1, 1'b1, 13'(c - 4)}) begin
          n_fail++;
          $display("FAIL w13_round_%0d: got %b/%b/%h want 1/1/%h", c - 4, c_ov, c_om, c_od, 13'(c - 4));
        end
      end
      if (c == 8192 + 4) begin
        n_tests++;
        if (c_ov !== 1'b0) begin n_fail++; $display("FAIL w13_drain: got %b want 0", c_ov); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure_fill();
    test_backpressure_random();
    test_reset_mid();
    test_w3_exhaustive();
    test_w13_roundtrip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
